// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer owning the PC; arbitrates misses, stalls, redirects.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          REFILL_TIMEOUT = 64,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icache_hit,
  input  logic                 refill_done,
  input  logic                 load_use_hazard,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [31:0]          pc,
  output logic [31:0]          next_pc,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 refill_req,
  output logic                 fetch_fault,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam int TW = (REFILL_TIMEOUT > 2) ? $clog2(REFILL_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(REFILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    REPLAY = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   redir_q;
  logic          redir_pend_q;
  logic          fault_q;

  logic          wr_d;
  logic          fl_d;
  logic          req_d;
  logic          miss_d;

  assign pc          = pc_q;
  assign next_pc     = pc_q + 32'd4;
  assign if_id_write = wr_d;
  assign if_id_flush = fl_d;
  assign refill_req  = req_d;
  assign fetch_fault = fault_q;

  // IF/ID control and refill request, forced idle while reset is held
  always_comb begin
    wr_d   = 1'b0;
    fl_d   = 1'b1;
    req_d  = 1'b0;
    miss_d = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            fl_d = 1'b1;
          end else if (!icache_hit) begin
            fl_d   = 1'b1;
            miss_d = 1'b1;
          end else if (load_use_hazard) begin
            fl_d = 1'b0;
          end else begin
            fl_d = 1'b0;
            wr_d = 1'b1;
          end
        end
        REFILL:  req_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Sequencer: state, PC, refill timeout and pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      tmo_q        <= '0;
      redir_q      <= '0;
      redir_pend_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            pc_q <= branch_target;
          end else if (!icache_hit) begin
            state_q <= REFILL;
            tmo_q   <= '0;
          end else if (!load_use_hazard) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        REFILL: begin
          if (refill_done) begin
            redir_pend_q <= 1'b0;
            if (branch_taken) begin
              pc_q    <= branch_target;
              state_q <= RUN;
            end else if (redir_pend_q) begin
              pc_q    <= redir_q;
              state_q <= RUN;
            end else begin
              state_q <= REPLAY;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (branch_taken) begin
              redir_q      <= branch_target;
              redir_pend_q <= 1'b1;
            end
          end
        end
        REPLAY: begin
          state_q <= RUN;
          if (branch_taken) begin
            pc_q <= branch_target;
          end
        end
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] miss_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  assign miss_cnt  = miss_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Saturating miss and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (miss_d && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      if ((!wr_d || fl_d) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end
`else
  assign miss_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors for fetch_ctrl with hand-computed expectations.
// Counter expectations follow whether PERF_CNT_EN is defined.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        icache_hit;
  logic        refill_done;
  logic        load_use_hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        if_id_write;
  logic        if_id_flush;
  logic        refill_req;
  logic        fetch_fault;
  logic [15:0] miss_cnt;
  logic [15:0] stall_cnt;

  int n_chk;
  int n_err;

`ifdef PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  fetch_ctrl #(
    .RESET_PC      (32'h0000_0000),
    .REFILL_TIMEOUT(4),
    .CNT_WIDTH     (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_hit     (icache_hit),
    .refill_done    (refill_done),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .pc             (pc),
    .next_pc        (next_pc),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .refill_req     (refill_req),
    .fetch_fault    (fetch_fault),
    .miss_cnt       (miss_cnt),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    icache_hit = 1'b1;
    refill_done = 1'b0;
    load_use_hazard = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", next_pc, 32'h4);
    chk("rst_wr", 32'(if_id_write), 32'd0);
    chk("rst_fl", 32'(if_id_flush), 32'd1);
    chk("rst_req", 32'(refill_req), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);

    // continuous hits
    rst = 1'b0;
    #1;
    chk("run_pc0", pc, 32'h0);
    chk("run_wr0", 32'(if_id_write), 32'd1);
    chk("run_fl0", 32'(if_id_flush), 32'd0);
    tick();
    chk("run_pc4", pc, 32'h4);
    tick();
    chk("run_pc8", pc, 32'h8);

    // miss at 8, refill_done on 3rd REFILL cycle
    icache_hit = 1'b0;
    #1;
    chk("miss_fl", 32'(if_id_flush), 32'd1);
    chk("miss_wr", 32'(if_id_write), 32'd0);
    chk("miss_req", 32'(refill_req), 32'd0);
    tick();
    chk("rf1_pc", pc, 32'h8);
    chk("rf1_req", 32'(refill_req), 32'd1);
    chk("rf1_fl", 32'(if_id_flush), 32'd1);
    tick();
    chk("rf2_req", 32'(refill_req), 32'd1);
    tick();
    refill_done = 1'b1;
    #1;
    chk("rf3_req", 32'(refill_req), 32'd1);
    tick();
    refill_done = 1'b0;
    icache_hit = 1'b1;
    #1;
    chk("rpl_req", 32'(refill_req), 32'd0);
    chk("rpl_fl", 32'(if_id_flush), 32'd1);
    chk("rpl_pc", pc, 32'h8);
    tick();
    chk("hit8_pc", pc, 32'h8);
    chk("hit8_wr", 32'(if_id_write), 32'd1);
    chk("hit8_fl", 32'(if_id_flush), 32'd0);
    chk("miss_cnt1", 32'(miss_cnt), 32'(PERF * 1));
    chk("stall_cnt5", 32'(stall_cnt), 32'(PERF * 5));
    tick();
    chk("hit_pcC", pc, 32'hC);

    // branch during REFILL, refill_done on 4th cycle
    icache_hit = 1'b0;
    tick();
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("brf2_req", 32'(refill_req), 32'd1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("brf3_pc", pc, 32'hC);
    chk("brf3_req", 32'(refill_req), 32'd1);
    tick();
    refill_done = 1'b1;
    #1;
    chk("brf4_req", 32'(refill_req), 32'd1);
    tick();
    refill_done = 1'b0;
    icache_hit = 1'b1;
    #1;
    chk("redir_pc", pc, 32'h100);
    chk("redir_wr", 32'(if_id_write), 32'd1);
    chk("miss_cnt2", 32'(miss_cnt), 32'(PERF * 2));
    chk("stall_cnt10", 32'(stall_cnt), 32'(PERF * 10));
    tick();
    chk("redir_pc4", pc, 32'h104);

    // branch beats load-use hazard
    load_use_hazard = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    #1;
    chk("lubr_fl", 32'(if_id_flush), 32'd1);
    chk("lubr_wr", 32'(if_id_write), 32'd0);
    tick();
    load_use_hazard = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("lubr_pc", pc, 32'h40);
    chk("lubr_wr1", 32'(if_id_write), 32'd1);
    load_use_hazard = 1'b1;
    #1;
    chk("lu_wr", 32'(if_id_write), 32'd0);
    chk("lu_fl", 32'(if_id_flush), 32'd0);
    tick();
    load_use_hazard = 1'b0;
    #1;
    chk("lu_pc", pc, 32'h40);
    chk("lu_wr1", 32'(if_id_write), 32'd1);
    tick();
    chk("lu_pc44", pc, 32'h44);

    // PC wrap
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    #1;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_npc", next_pc, 32'h0);
    chk("wrap_wr", 32'(if_id_write), 32'd1);
    tick();
    chk("wrap_pc0", pc, 32'h0);

    // stray refill_done in RUN
    refill_done = 1'b1;
    #1;
    chk("stray_req", 32'(refill_req), 32'd0);
    chk("stray_wr", 32'(if_id_write), 32'd1);
    tick();
    refill_done = 1'b0;
    #1;
    chk("stray_pc", pc, 32'h4);

    // refill timeout -> FAULT
    icache_hit = 1'b0;
    tick();
    chk("to1_req", 32'(refill_req), 32'd1);
    tick();
    tick();
    tick();
    chk("to4_req", 32'(refill_req), 32'd1);
    chk("to4_fault", 32'(fetch_fault), 32'd0);
    tick();
    chk("flt_fault", 32'(fetch_fault), 32'd1);
    chk("flt_req", 32'(refill_req), 32'd0);
    chk("flt_fl", 32'(if_id_flush), 32'd1);
    chk("flt_wr", 32'(if_id_write), 32'd0);
    chk("flt_pc", pc, 32'h4);
    branch_taken = 1'b1;
    branch_target = 32'h200;
    refill_done = 1'b1;
    icache_hit = 1'b1;
    tick();
    tick();
    chk("flt_hold_pc", pc, 32'h4);
    chk("flt_hold_fault", 32'(fetch_fault), 32'd1);
    chk("flt_hold_req", 32'(refill_req), 32'd0);
    branch_taken = 1'b0;
    refill_done = 1'b0;
    rst = 1'b1;
    #1;
    chk("flt_rst_fault", 32'(fetch_fault), 32'd0);
    chk("flt_rst_pc", pc, 32'h0);
    chk("flt_rst_miss", 32'(miss_cnt), 32'd0);

    // refill_done on the timeout cycle -> REPLAY
    tick();
    rst = 1'b0;
    icache_hit = 1'b0;
    tick();
    tick();
    tick();
    tick();
    refill_done = 1'b1;
    #1;
    chk("tw4_req", 32'(refill_req), 32'd1);
    tick();
    refill_done = 1'b0;
    icache_hit = 1'b1;
    #1;
    chk("tw_rpl_req", 32'(refill_req), 32'd0);
    chk("tw_rpl_fault", 32'(fetch_fault), 32'd0);
    chk("tw_rpl_fl", 32'(if_id_flush), 32'd1);
    chk("tw_rpl_pc", pc, 32'h0);
    tick();
    chk("tw_run_pc", pc, 32'h0);
    chk("tw_run_wr", 32'(if_id_write), 32'd1);
    tick();
    chk("tw_run_pc4", pc, 32'h4);

    // reset mid-refill drops refill_req at once
    icache_hit = 1'b0;
    tick();
    chk("mr_req", 32'(refill_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_rst_req", 32'(refill_req), 32'd0);
    tick();
    rst = 1'b0;
    icache_hit = 1'b1;
    refill_done = 1'b1;
    #1;
    chk("mr_stray_req", 32'(refill_req), 32'd0);
    chk("mr_stray_wr", 32'(if_id_write), 32'd1);
    chk("mr_stray_pc", pc, 32'h0);
    tick();
    refill_done = 1'b0;
    #1;
    chk("mr_pc4", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

- Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Owns the PC register and generates the IF/ID register's write-enable and flush, plus the `next_pc` value it captures.
- Arbitrates I-cache misses (refill handshake), load-use stalls and taken-branch redirects.
- Sits between the I-cache, the hazard-detect logic in ID and branch resolution in EX.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- REFILL_TIMEOUT, 64, maximum cycles spent in REFILL before declaring a fault (≥2).
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_hit  in  1  I-cache hit for the address on `pc` this cycle.
- refill_done  in  1  one-cycle pulse: line refill complete.
- load_use_hazard  in  1  from ID: stall IF and ID one cycle.
- branch_taken  in  1  from EX: redirect fetch this cycle.
- branch_target  in  32  redirect address; valid with branch_taken.
- pc  out  32  current fetch address, drives the I-cache.
- next_pc  out  32  pc + 4, wraps modulo 2^32; to IF/ID `next_pc`.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP with hit=0. Overrides if_id_write.
- refill_req  out  1  refill request; level signal held until refill_done.
- fetch_fault  out  1  sticky: refill timeout occurred.
- miss_cnt  out  CNT_WIDTH  I-cache miss count.
- stall_cnt  out  CNT_WIDTH  cycles with IF not advancing.

## Operation

States: RUN, REFILL, REPLAY, FAULT. Reset state is RUN.

RUN:
- Priority is branch_taken > miss > load_use_hazard.
- branch_taken: pc <= branch_target, flush=1. No refill even if icache_hit=0.
- Miss (icache_hit=0): pc held, flush=1, go to REFILL, timeout counter <= 0.
- load_use_hazard with hit: pc held, write=0, flush=0.
- Otherwise: pc <= pc+4, write=1.

REFILL:
- refill_req=1, pc held, flush=1. Timeout counter increments each cycle.
- branch_taken: latch branch_target into redirect register, set redir_pend. Later branches overwrite it.
- refill_done: if redir_pend, pc <= redirect and go to RUN; otherwise go to REPLAY. Clears redir_pend.
- Counter reaches REFILL_TIMEOUT-1 without refill_done: go to FAULT.
- refill_done in the same cycle as the timeout: refill_done wins.

REPLAY:
- One cycle. refill_req=0, pc held, flush=1, go to RUN.
- Icache re-presents the line; the hit is sampled in RUN next cycle.
- branch_taken: pc <= branch_target, go to RUN.

FAULT:
- pc held, flush=1, refill_req=0, fetch_fault=1. All inputs ignored.
- Exit only via rst.

## Timing

- pc, state, timeout counter, redirect register and counters are registered.
- if_id_write, if_id_flush and refill_req are combinational from state and inputs.
- While rst is high:
  - pc=RESET_PC, next_pc=RESET_PC+4.
  - if_id_write=0, if_id_flush=1.
  - refill_req=0, fetch_fault=0, counters=0, redir_pend=0.
- Reset asserted mid-refill: refill_req drops immediately (asynchronous). A later stray refill_done in RUN is ignored.
- Redirect latency: branch_target appears on pc the cycle after branch_taken in RUN or REPLAY. In REFILL, it appears the cycle after refill_done.
- Minimum miss penalty: 1 (RUN miss) + N (REFILL, refill_done on its Nth cycle) + 1 (REPLAY) cycles before the refetched instruction enters IF/ID.

## Configuration

- PERF_CNT_EN defined:
  - miss_cnt increments on each RUN→REFILL transition.
  - stall_cnt increments on every cycle with if_id_write=0 or if_id_flush=1, outside reset.
  - Both saturate at all-ones.
- PERF_CNT_EN undefined: miss_cnt and stall_cnt are tied to 0 and no counter flops are built. Ports remain present.

## Test plan

- Reset release with RESET_PC=0 and continuous hits -> pc sequence 0,4,8,C; if_id_write=1 and flush=0 from the first cycle after rst deasserts.
- icache_hit=0 at pc=8, refill_done on the 3rd REFILL cycle -> refill_req high 3 cycles, then one REPLAY cycle, then pc=8 hits and advances to C; flush=1 throughout; miss_cnt=1, stall_cnt=5.
- branch_taken (target 0x100) in the 2nd REFILL cycle, refill_done in the 4th -> no REPLAY; pc=0x100 the cycle after refill_done.
- load_use_hazard and branch_taken (target 0x40) in the same RUN cycle -> pc=0x40 next cycle, flush=1; load_use_hazard alone -> pc held, write=0, flush=0.
- REFILL_TIMEOUT=4 with no refill_done -> FAULT after 4 REFILL cycles; fetch_fault=1 and pc frozen until rst; refill_done on the 4th cycle instead -> REPLAY, no fault.
- pc=0xFFFF_FFFC with a hit -> next_pc=0, pc wraps to 0.
